// File: rtl/demux1x2_reg_if.sv
// Bus bundle for the registered 1-to-2 demultiplexer.
// Handshake rule for every stream on this bus: a word moves on a rising
// edge where valid and ready are both high. A source holds its word and
// valid steady until that edge. Ready may depend on state and on S, but
// never on the valid of the same stream.
interface demux1x2_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] In;
    logic             S;
    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] Y0;
    logic             Y0_valid;
    logic             Y0_ready;
    logic [WIDTH-1:0] Y1;
    logic             Y1_valid;
    logic             Y1_ready;
    logic [CNT_W-1:0] Cnt0;
    logic [CNT_W-1:0] Cnt1;

    // Producer/consumer side (drives In, S, In_valid and the output readies)
    modport master (
        output In, S, In_valid, Y0_ready, Y1_ready,
        input  In_ready, Y0, Y0_valid, Y1, Y1_valid, Cnt0, Cnt1
    );

    // Demux side
    modport slave (
        input  In, S, In_valid, Y0_ready, Y1_ready,
        output In_ready, Y0, Y0_valid, Y1, Y1_valid, Cnt0, Cnt1
    );
endinterface

// File: rtl/demux1x2_reg.sv
// Registered 1-to-2 demultiplexer. Each output channel has its own holding
// register, so a stalled consumer only ever blocks words addressed to it.
// Per-channel state is EMPTY/FULL and is visible directly as Yk_valid.
module demux1x2_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    demux1x2_reg_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t        st0, st0_nxt;
    ch_state_t        st1, st1_nxt;
    logic [WIDTH-1:0] y0_q, y1_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;
    logic             in_ready;
    logic             load0, load1;
    logic             drain0, drain1;

    // In_ready follows the selected channel only; held low during reset
    assign in_ready = rst_n & (bus.S ? ((st1 == EMPTY) | bus.Y1_ready)
                                     : ((st0 == EMPTY) | bus.Y0_ready));

    assign load0  = bus.In_valid & in_ready & ~bus.S;
    assign load1  = bus.In_valid & in_ready &  bus.S;
    assign drain0 = (st0 == FULL) & bus.Y0_ready;
    assign drain1 = (st1 == FULL) & bus.Y1_ready;

    // Next channel state: a load wins (FULL), a lone drain empties
    always_comb begin
        st0_nxt = st0;
        st1_nxt = st1;
        if (load0)       st0_nxt = FULL;
        else if (drain0) st0_nxt = EMPTY;
        if (load1)       st1_nxt = FULL;
        else if (drain1) st1_nxt = EMPTY;
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st0 <= EMPTY;
            st1 <= EMPTY;
        end else begin
            st0 <= st0_nxt;
            st1 <= st1_nxt;
        end
    end

    // Holding registers capture In only on a load; a drain leaves data as is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_q <= '0;
            y1_q <= '0;
        end else begin
            if (load0) y0_q <= bus.In;
            if (load1) y1_q <= bus.In;
        end
    end

    // Completed output handshakes per channel, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (drain0) cnt0_q <= cnt0_q + 1'b1;
            if (drain1) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign bus.In_ready = in_ready;
    assign bus.Y0       = y0_q;
    assign bus.Y1       = y1_q;
    assign bus.Y0_valid = (st0 == FULL);
    assign bus.Y1_valid = (st1 == FULL);
    assign bus.Cnt0     = cnt0_q;
    assign bus.Cnt1     = cnt1_q;
endmodule

// File: tb/tb_demux1x2_reg.sv
// Directed bench for demux1x2_reg: reset, stall isolation, streaming,
// simultaneous load/drain, counter wrap and asynchronous mid-run reset.
module tb_demux1x2_reg;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    demux1x2_reg_if #(.WIDTH(8), .CNT_W(8)) bus ();

    demux1x2_reg #(.WIDTH(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.In = 8'h00;
        bus.S = 1'b0;
        bus.In_valid = 1'b0;
        bus.Y0_ready = 1'b0;
        bus.Y1_ready = 1'b0;

        // Reset held
        repeat (3) tick();
        check("rst_in_ready", {31'd0, bus.In_ready}, 32'd0);
        check("rst_y0_valid", {31'd0, bus.Y0_valid}, 32'd0);
        check("rst_y1_valid", {31'd0, bus.Y1_valid}, 32'd0);
        check("rst_y0", {24'd0, bus.Y0}, 32'd0);
        check("rst_y1", {24'd0, bus.Y1}, 32'd0);
        check("rst_cnt0", {24'd0, bus.Cnt0}, 32'd0);
        check("rst_cnt1", {24'd0, bus.Cnt1}, 32'd0);

        // Release and first accept
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, bus.In_ready}, 32'd1);
        bus.In = 8'hA5; bus.S = 1'b0; bus.In_valid = 1'b1;
        tick();
        bus.In_valid = 1'b0;
        check("first_y0", {24'd0, bus.Y0}, 32'hA5);
        check("first_y0_valid", {31'd0, bus.Y0_valid}, 32'd1);
        check("first_y1_valid", {31'd0, bus.Y1_valid}, 32'd0);

        // Drain A5: Cnt0 = 1
        bus.Y0_ready = 1'b1;
        tick();
        bus.Y0_ready = 1'b0;
        check("drain_a5_cnt0", {24'd0, bus.Cnt0}, 32'd1);
        check("drain_a5_y0_valid", {31'd0, bus.Y0_valid}, 32'd0);

        // Stall isolation: Y0 stuck with 11, 22 redirected to ch1
        bus.In = 8'h11; bus.S = 1'b0; bus.In_valid = 1'b1;
        tick();
        bus.In = 8'h22;
        #1;
        check("stall_in_ready_s0", {31'd0, bus.In_ready}, 32'd0);
        tick();
        check("stall_y0_hold", {24'd0, bus.Y0}, 32'h11);
        check("stall_y1_valid", {31'd0, bus.Y1_valid}, 32'd0);
        bus.S = 1'b1;
        #1;
        check("stall_in_ready_s1", {31'd0, bus.In_ready}, 32'd1);
        tick();
        bus.In_valid = 1'b0;
        check("stall_y1", {24'd0, bus.Y1}, 32'h22);
        check("stall_y1_valid2", {31'd0, bus.Y1_valid}, 32'd1);
        check("stall_y0_still", {24'd0, bus.Y0}, 32'h11);

        // Drain 22 from ch1: Cnt1 = 1
        bus.Y1_ready = 1'b1;
        tick();
        check("drain_22_cnt1", {24'd0, bus.Cnt1}, 32'd1);

        // Streaming 1..4 into ch1 with Y1_ready held high
        bus.S = 1'b1; bus.In_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.In = 8'(i);
            #1;
            check("stream_in_ready", {31'd0, bus.In_ready}, 32'd1);
            tick();
            check("stream_y1", {24'd0, bus.Y1}, 32'(i));
            check("stream_y1_valid", {31'd0, bus.Y1_valid}, 32'd1);
        end
        bus.In_valid = 1'b0;
        tick();
        // 1 (word 22) + 4 streamed words
        check("stream_cnt1", {24'd0, bus.Cnt1}, 32'd5);
        check("stream_y1_empty", {31'd0, bus.Y1_valid}, 32'd0);
        // Ready with nothing held does not count
        tick();
        check("idle_ready_cnt1", {24'd0, bus.Cnt1}, 32'd5);
        bus.Y1_ready = 1'b0;

        // Drain 11 from ch0: Cnt0 = 2
        bus.Y0_ready = 1'b1;
        tick();
        bus.Y0_ready = 1'b0;
        check("drain_11_cnt0", {24'd0, bus.Cnt0}, 32'd2);

        // Simultaneous load and drain
        bus.In = 8'h33; bus.S = 1'b0; bus.In_valid = 1'b1;
        tick();
        check("sim_y0_33", {24'd0, bus.Y0}, 32'h33);
        bus.In = 8'h44; bus.Y0_ready = 1'b1;
        tick();
        check("sim_y0_44", {24'd0, bus.Y0}, 32'h44);
        check("sim_y0_valid", {31'd0, bus.Y0_valid}, 32'd1);
        check("sim_cnt0", {24'd0, bus.Cnt0}, 32'd3);

        // Counter wrap: keep streaming into ch0, one drain per edge
        for (int i = 0; i < 252; i++) begin
            bus.In = 8'(i);
            tick();
        end
        check("wrap_cnt0_255", {24'd0, bus.Cnt0}, 32'd255);
        bus.In = 8'h5A;
        tick();
        check("wrap_cnt0_0", {24'd0, bus.Cnt0}, 32'd0);
        check("wrap_cnt1_same", {24'd0, bus.Cnt1}, 32'd5);
        bus.In = 8'h77;
        tick();
        check("wrap_cnt0_1", {24'd0, bus.Cnt0}, 32'd1);
        check("wrap_y0", {24'd0, bus.Y0}, 32'h77);
        bus.Y0_ready = 1'b0;

        // Fill ch1 as well
        bus.In = 8'h66; bus.S = 1'b1;
        tick();
        bus.In_valid = 1'b0;
        check("pre_rst_y0_valid", {31'd0, bus.Y0_valid}, 32'd1);
        check("pre_rst_y1_valid", {31'd0, bus.Y1_valid}, 32'd1);
        check("pre_rst_y1", {24'd0, bus.Y1}, 32'h66);

        // Asynchronous reset mid-cycle, checked well before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_y0_valid", {31'd0, bus.Y0_valid}, 32'd0);
        check("arst_y1_valid", {31'd0, bus.Y1_valid}, 32'd0);
        check("arst_cnt0", {24'd0, bus.Cnt0}, 32'd0);
        check("arst_cnt1", {24'd0, bus.Cnt1}, 32'd0);
        check("arst_y0", {24'd0, bus.Y0}, 32'd0);
        check("arst_in_ready", {31'd0, bus.In_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
